// File: rtl/exec_alu_datapath.sv
// rtl/exec_alu_datapath.sv - execute-stage ALU with operand-B select, pipelined multiply and PC target adder
module exec_alu_datapath #(
  parameter int WORD_SIZE  = 32,
  parameter int MUL_STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WORD_SIZE-1:0] src_a,
  input  logic [WORD_SIZE-1:0] write_data,
  input  logic [WORD_SIZE-1:0] imm_ext,
  input  logic                 alu_src,
  input  logic [2:0]           alu_control,
  input  logic [WORD_SIZE-1:0] pc,
  output logic [WORD_SIZE-1:0] alu_result,
  output logic                 zero,
  output logic [WORD_SIZE-1:0] pc_target
);

  logic [WORD_SIZE-1:0] w_src_b;
  logic [WORD_SIZE-1:0] w_mul_lo;
  logic                 w_slt;
  logic                 w_sltu;
  logic [WORD_SIZE-1:0] r_prod [MUL_STAGES];

  assign w_src_b   = alu_src ? imm_ext : write_data;
  assign pc_target = pc + imm_ext;
  assign w_mul_lo  = src_a * w_src_b;
  assign w_slt     = $signed(src_a) < $signed(w_src_b);
  assign w_sltu    = src_a < w_src_b;

  // Product shifts every edge regardless of op; the consumer's stall counter masks stale stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < MUL_STAGES; k++) begin
        r_prod[k] <= '0;
      end
    end else begin
      r_prod[0] <= w_mul_lo;
      for (int k = 1; k < MUL_STAGES; k++) begin
        r_prod[k] <= r_prod[k-1];
      end
    end
  end

  always_comb begin
    alu_result = '0;
    case (alu_control)
      3'b000:  alu_result = src_a + w_src_b;
      3'b001:  alu_result = src_a - w_src_b;
      3'b010:  alu_result = src_a & w_src_b;
      3'b011:  alu_result = src_a | w_src_b;
      3'b100:  alu_result = r_prod[MUL_STAGES-1];
      3'b101:  alu_result = {{(WORD_SIZE-1){1'b0}}, w_slt};
      3'b110:  alu_result = src_a ^ w_src_b;
      default: alu_result = {{(WORD_SIZE-1){1'b0}}, w_sltu};
    endcase
  end

  assign zero = (alu_result == '0);

endmodule

// File: tb/tb_exec_alu_datapath.sv
// tb/tb_exec_alu_datapath.sv - randomized self-checking bench for exec_alu_datapath
module tb_exec_alu_datapath;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] src_a, write_data, imm_ext, pc;
  logic        alu_src;
  logic [2:0]  alu_control;
  logic [31:0] alu_result, pc_target;
  logic        zero;

  int n_checks = 0;
  int n_errors = 0;

  // Products issued at each past edge; index 0 is the most recent.
  logic [31:0] mul_hist [$];

  exec_alu_datapath #(.WORD_SIZE(32), .MUL_STAGES(4)) dut (
    .clk(clk), .rst(rst), .src_a(src_a), .write_data(write_data),
    .imm_ext(imm_ext), .alu_src(alu_src), .alu_control(alu_control),
    .pc(pc), .alu_result(alu_result), .zero(zero), .pc_target(pc_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cur_b();
    return alu_src ? imm_ext : write_data;
  endfunction

  function automatic logic [31:0] ref_result();
    logic [31:0] a, b;
    a = src_a;
    b = cur_b();
    case (alu_control)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return mul_hist[3];
      3'd5:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6:    return a ^ b;
      default: return (a < b) ? 32'd1 : 32'd0;
    endcase
  endfunction

  task automatic model_clear();
    mul_hist = {32'd0, 32'd0, 32'd0, 32'd0};
  endtask

  task automatic tick();
    logic [63:0] full;
    @(posedge clk);
    if (!rst) begin
      full = 64'(src_a) * 64'(cur_b());
      mul_hist.push_front(full[31:0]);
      void'(mul_hist.pop_back());
    end
    #1;
  endtask

  task automatic apply(input logic [31:0] a, input logic [31:0] wd, input logic [31:0] imm,
                       input logic sel, input logic [2:0] op, input logic [31:0] pcv);
    src_a = a; write_data = wd; imm_ext = imm; alu_src = sel; alu_control = op; pc = pcv;
    #1;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] exp;
    exp = ref_result();
    check({tag, ".result"}, alu_result, exp);
    check({tag, ".zero"}, {31'd0, zero}, {31'd0, exp == 32'd0});
    check({tag, ".target"}, pc_target, pc + imm_ext);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_clear();
    check("rst.mul", alu_result, (alu_control == 3'd4) ? 32'd0 : ref_result());
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] a, wd, imm, pcv;
    rst = 1'b1;
    model_clear();
    apply(32'd6, 32'd7, 32'd0, 1'b0, 3'd4, 32'd0);
    tick();
    check("reset.mul", alu_result, 32'd0);
    check("reset.zero", {31'd0, zero}, 32'd1);
    rst = 1'b0;

    apply(32'd5, 32'd7, 32'd3, 1'b0, 3'd0, 32'd0);
    check("sel.reg", alu_result, 32'd12);
    apply(32'd5, 32'd7, 32'd3, 1'b1, 3'd0, 32'd0);
    check("sel.imm", alu_result, 32'd8);

    apply(32'h10, 32'h10, 32'd0, 1'b0, 3'd1, 32'd0);
    check("sub.eq", alu_result, 32'd0);
    check("sub.eq.zero", {31'd0, zero}, 32'd1);
    apply(32'h10, 32'h11, 32'd0, 1'b0, 3'd1, 32'd0);
    check("sub.neg", alu_result, 32'hFFFF_FFFF);
    check("sub.neg.zero", {31'd0, zero}, 32'd0);

    apply(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'd5, 32'd0);
    check("slt", alu_result, 32'd1);
    apply(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'd7, 32'd0);
    check("sltu", alu_result, 32'd0);
    apply(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 3'd0, 32'd0);
    check("add.wrap", alu_result, 32'd0);
    check("add.wrap.zero", {31'd0, zero}, 32'd1);

    apply(32'd0, 32'd0, 32'hFFFF_FFF8, 1'b0, 3'd0, 32'h100);
    check("target.neg", pc_target, 32'hF8);
    apply(32'd0, 32'd0, 32'd8, 1'b0, 3'd0, 32'hFFFF_FFFC);
    check("target.wrap", pc_target, 32'h4);

    // Multiply latency from a clean pipeline
    apply(32'd6, 32'd7, 32'd0, 1'b0, 3'd4, 32'd0);
    pulse_reset();
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("mul.edge%0d", e), alu_result, (e == 4) ? 32'd42 : 32'd0);
    end
    apply(32'h10000, 32'h10000, 32'd0, 1'b0, 3'd4, 32'd0);
    for (int e = 0; e < 4; e++) tick();
    check("mul.lowhalf", alu_result, 32'd0);
    check("mul.lowhalf.zero", {31'd0, zero}, 32'd1);

    // Reset mid-multiply
    apply(32'd6, 32'd7, 32'd0, 1'b0, 3'd4, 32'd0);
    tick();
    tick();
    rst = 1'b1;
    #1;
    check("midrst.mul", alu_result, 32'd0);
    check("midrst.zero", {31'd0, zero}, 32'd1);
    apply(32'd3, 32'd3, 32'd0, 1'b0, 3'd0, 32'd0);
    check("midrst.comb_live", alu_result, 32'd6);
    apply(32'd6, 32'd7, 32'd0, 1'b0, 3'd4, 32'd0);
    rst = 1'b0;
    model_clear();
    for (int e = 1; e <= 4; e++) begin
      tick();
      if (e >= 3) check($sformatf("midrst.edge%0d", e), alu_result, (e == 4) ? 32'd42 : 32'd0);
    end

    // Randomized run against the model, with held operands and occasional resets
    a = 0; wd = 0; imm = 0; pcv = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 2) != 0) begin
        a   = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        wd  = ($urandom_range(0, 3) == 0) ? a : $urandom;
        imm = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        pcv = $urandom;
      end
      apply(a, wd, imm, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), pcv);
      if ($urandom_range(0, 29) == 0) pulse_reset();
      check_all($sformatf("rand%0d", i));
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
